// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared CPU package: operand fetch FSM states and width defaults
package operand_fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RA_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD1  = 2'd1,
    ST_RD2  = 2'd2,
    ST_HOLD = 2'd3
  } of_state_t;

endpackage

// File: rtl/opfetch_bypass.sv
// rtl/opfetch_bypass.sv - operand select: x0 forces zero, a matching writeback wins over the base value
module opfetch_bypass #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_addr,
  input  logic [XLEN-1:0] i_base,
  input  logic            i_wb_we,
  input  logic [RA_W-1:0] i_wb_addr,
  input  logic [XLEN-1:0] i_wb_data,
  output logic [XLEN-1:0] o_data
);

  // Priority: register 0 is hardwired to zero, then the in-flight writeback, then the base value
  always_comb begin
    o_data = i_base;
    if (i_addr == '0) begin
      o_data = '0;
    end else if (i_wb_we && (i_wb_addr == i_addr)) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage: sequential rs1/rs2 reads over one register file port
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_use_rs2,
  input  logic [XLEN-1:0] in_imm,
  output logic [RA_W-1:0] rf_read_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] out_imm
);

  of_state_t       r_state;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [XLEN-1:0] r_imm;
  logic            r_use_rs2;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;

  logic [RA_W-1:0] w_rd_addr;
  logic [XLEN-1:0] w_rd_data;
  logic [XLEN-1:0] w_snp_rs1;
  logic [XLEN-1:0] w_snp_rs2;

  // The single read port is steered by state; it idles at x0 so no stray index leaks out
  always_comb begin
    w_rd_addr = '0;
    if (r_state == ST_RD1) begin
      w_rd_addr = r_rs1;
    end else if (r_state == ST_RD2) begin
      w_rd_addr = r_rs2;
    end
  end

  opfetch_bypass #(.XLEN(XLEN), .RA_W(RA_W)) u_read_sel (
    .i_addr    (w_rd_addr),
    .i_base    (rf_data),
    .i_wb_we   (wb_we),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_data),
    .o_data    (w_rd_data)
  );

  // Snoop paths keep the already-latched operands coherent with later writebacks
  opfetch_bypass #(.XLEN(XLEN), .RA_W(RA_W)) u_snoop_rs1 (
    .i_addr    (r_rs1),
    .i_base    (r_rs1_val),
    .i_wb_we   (wb_we),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_data),
    .o_data    (w_snp_rs1)
  );

  opfetch_bypass #(.XLEN(XLEN), .RA_W(RA_W)) u_snoop_rs2 (
    .i_addr    (r_rs2),
    .i_base    (r_rs2_val),
    .i_wb_we   (wb_we),
    .i_wb_addr (wb_addr),
    .i_wb_data (wb_data),
    .o_data    (w_snp_rs2)
  );

  // Control FSM: accept, read rs1, optionally read rs2, then hold operands until execute takes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_use_rs2 <= 1'b0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_rs1     <= in_rs1;
            r_rs2     <= in_rs2;
            r_rd      <= in_rd;
            r_imm     <= in_imm;
            r_use_rs2 <= in_use_rs2;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_state   <= ST_RD1;
          end
        end
        ST_RD1: begin
          r_rs1_val <= w_rd_data;
          r_state   <= r_use_rs2 ? ST_RD2 : ST_HOLD;
        end
        ST_RD2: begin
          r_rs2_val <= w_rd_data;
          r_rs1_val <= w_snp_rs1;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          // Once execute accepts, a coincident writeback belongs to the next instruction's reads
          if (out_ready) begin
            r_state <= ST_IDLE;
          end else begin
            r_rs1_val <= w_snp_rs1;
            if (r_use_rs2) begin
              r_rs2_val <= w_snp_rs2;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign out_valid    = (r_state == ST_HOLD);
  assign rf_read_addr = w_rd_addr;
  assign out_rs1_val  = r_rs1_val;
  assign out_rs2_val  = r_rs2_val;
  assign out_rd       = r_rd;
  assign out_imm      = r_imm;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_use_rs2;
  logic [31:0] in_imm;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;

  logic [31:0] regs [0:31];
  logic        rf_force;
  int          n_checks;
  int          n_errors;

  operand_fetch #(.XLEN(32), .RA_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_use_rs2   (in_use_rs2),
    .in_imm       (in_imm),
    .rf_read_addr (rf_read_addr),
    .rf_data      (rf_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs1_val  (out_rs1_val),
    .out_rs2_val  (out_rs2_val),
    .out_rd       (out_rd),
    .out_imm      (out_imm)
  );

  assign rf_data = rf_force ? 32'hFFFF_FFFF : regs[rf_read_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, optionally pulse a writeback at negedge index wb_at,
  // keep out_ready low for hold_cycles HOLD cycles, then release and check outputs.
  task automatic run_instr(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic use2, input logic [31:0] imm,
                           input int wb_at, input logic [4:0] wba, input logic [31:0] wbd,
                           input int hold_cycles, input logic [31:0] exp1,
                           input logic [31:0] exp2, input int exp_lat);
    int lat;
    int hold_n;
    bit done;
    lat = 0;
    hold_n = 0;
    done = 0;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_use_rs2 = use2; in_imm = imm;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      wb_we = (n == wb_at);
      wb_addr = wba;
      wb_data = wbd;
      if (n == 1) check_eq({tag, ".addr_rs1"}, {27'd0, rf_read_addr}, {27'd0, rs1});
      if (n == 2 && use2) check_eq({tag, ".addr_rs2"}, {27'd0, rf_read_addr}, {27'd0, rs2});
      if (!use2) check_eq({tag, ".addr_not_rs2"}, {31'd0, rf_read_addr == rs2}, 32'd0);
      if (lat == 0 && out_valid) begin
        lat = n;
        check_eq({tag, ".latency"}, lat, exp_lat);
      end
      if (lat != 0) begin
        hold_n++;
        check_eq({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
        check_eq({tag, ".imm"}, out_imm, imm);
        check_eq({tag, ".rs1_val"}, out_rs1_val, exp1);
        if (hold_n > hold_cycles) begin
          check_eq({tag, ".rs2_val"}, out_rs2_val, exp2);
          out_ready = 1'b1;
          done = 1;
          break;
        end
      end
    end
    if (!done) check_eq({tag, ".timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    wb_we = 1'b0;
    out_ready = 1'b0;
    check_eq({tag, ".after_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, ".after_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rf_force = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    regs[3] = 32'h11;
    regs[4] = 32'h22;
    regs[5] = 32'h55;
    regs[7] = 32'h77;
    regs[8] = 32'h88;
    rst = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_rs2 = 1'b0; in_imm = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b0;
    #1;
    check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst.rf_addr", {27'd0, rf_read_addr}, 32'd0);
    check_eq("rst.rs1_val", out_rs1_val, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_instr("basic", 5'd3, 5'd4, 5'd10, 1'b1, 32'hCAFE, 0, 5'd0, 32'd0, 0,
              32'h11, 32'h22, 3);

    rf_force = 1'b1;
    run_instr("x0", 5'd0, 5'd0, 5'd1, 1'b1, 32'h1, 0, 5'd0, 32'd0, 0,
              32'h0, 32'h0, 3);
    rf_force = 1'b0;

    run_instr("byp", 5'd5, 5'd6, 5'd2, 1'b0, 32'h2, 1, 5'd5, 32'hABCD, 0,
              32'hABCD, 32'h0, 2);
    run_instr("byp0", 5'd5, 5'd6, 5'd2, 1'b0, 32'h3, 1, 5'd0, 32'hABCD, 0,
              32'h55, 32'h0, 2);

    run_instr("hold", 5'd3, 5'd7, 5'd12, 1'b1, 32'h4, 4, 5'd7, 32'h99, 5,
              32'h11, 32'h99, 3);

    run_instr("rd2snp", 5'd8, 5'd9, 5'd13, 1'b1, 32'h5, 2, 5'd8, 32'h1234, 0,
              32'h1234, 32'h1009, 3);

    run_instr("no_rs2", 5'd4, 5'd3, 5'd14, 1'b0, 32'h6, 0, 5'd0, 32'd0, 0,
              32'h22, 32'h0, 2);

    // Reset while in RD2
    @(negedge clk);
    in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd15; in_use_rs2 = 1'b1; in_imm = 32'h7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rstmid.pre_addr", {27'd0, rf_read_addr}, 32'd4);
    #1 rst = 1'b1;
    #1;
    check_eq("rstmid.out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rstmid.rf_addr", {27'd0, rf_read_addr}, 32'd0);
    check_eq("rstmid.rs1_val", out_rs1_val, 32'd0);
    check_eq("rstmid.rd", {27'd0, out_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_instr("post_rst", 5'd4, 5'd3, 5'd16, 1'b1, 32'h8, 0, 5'd0, 32'd0, 0,
              32'h22, 32'h11, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
